// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// The FSM, the write mux and the pending scoreboard all import this package.
package regfile_wport_arbiter_pkg;

    localparam int ADDR_W      = 5;
    localparam int NREGS       = 1 << ADDR_W;
    localparam int RF_ADDR_PAD = 27;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FORCE
    } arb_state_t;

endpackage

// File: rtl/regfile_wport_arbiter_sb.sv
// Pending-destination scoreboard: one bit per register still owed by the LU.
// A set and a clear of the same register in one cycle leave the bit set.
module reg_pending_sb
    import regfile_wport_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [NREGS-1:0]  pending,
    output logic              hit_rs,
    output logic              hit_rt
);

    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;

    // $0 is never owed, so an issue to it must not mark anything.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en && set_addr != REG_ZERO) begin
            set_mask[set_addr] = 1'b1;
        end
        if (clr_en) begin
            clr_mask[clr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    assign hit_rs = pending[rs_addr] && (rs_addr != REG_ZERO);
    assign hit_rt = pending[rt_addr] && (rt_addr != REG_ZERO);

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Shares the single regfile write port between WB (priority) and the LU,
// forcing an LU grant after MAX_WAIT denied cycles by stalling WB once.
module regfile_wport_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [31:0]       wb_wdata,
    output logic              wb_stall,
    input  logic              lu_issue,
    input  logic [ADDR_W-1:0] lu_issue_addr,
    input  logic              lu_valid,
    input  logic [ADDR_W-1:0] lu_waddr,
    input  logic [31:0]       lu_wdata,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              hazard_rs,
    output logic              hazard_rt,
    output logic              rf_we,
    output logic [31:0]       rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic [31:0]       pending
);

    import regfile_wport_arbiter_pkg::*;

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [3:0]        wait_cnt;
    logic [3:0]        wait_nxt;
    logic              sel_lu;
    logic              sel_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic              hit_rs;
    logic              hit_rt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Grants are combinational so the regfile commits on the same edge.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        wb_stall  = 1'b0;
        lu_ready  = 1'b0;
        sel_lu    = 1'b0;
        sel_valid = 1'b0;
        if (!rst) begin
            case (state)
                FORCE: begin
                    wb_stall  = 1'b1;
                    lu_ready  = 1'b1;
                    sel_lu    = 1'b1;
                    sel_valid = lu_valid;
                    state_nxt = IDLE;
                    wait_nxt  = '0;
                end
                default: begin
                    state_nxt = IDLE;
                    wait_nxt  = '0;
                    if (wb_we) begin
                        sel_valid = 1'b1;
                        if (lu_valid) begin
                            wait_nxt  = wait_cnt + 4'd1;
                            state_nxt = (wait_nxt == 4'(MAX_WAIT)) ? FORCE : WAIT;
                        end
                    end else if (lu_valid) begin
                        lu_ready  = 1'b1;
                        sel_lu    = 1'b1;
                        sel_valid = 1'b1;
                    end
                end
            endcase
        end
    end

    assign sel_addr = sel_lu ? lu_waddr : wb_waddr;
    assign rf_we    = sel_valid && (sel_addr != REG_ZERO);
    assign rf_waddr = {{RF_ADDR_PAD{1'b0}}, sel_addr};
    assign rf_wdata = sel_lu ? lu_wdata : wb_wdata;

    reg_pending_sb u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (lu_issue),
        .set_addr (lu_issue_addr),
        .clr_en   (lu_valid && lu_ready),
        .clr_addr (lu_waddr),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .pending  (pending),
        .hit_rs   (hit_rs),
        .hit_rt   (hit_rt)
    );

    assign hazard_rs = !rst && hit_rs;
    assign hazard_rt = !rst && hit_rt;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Bench for regfile_wport_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_regfile_wport_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_stall;
    logic        lu_issue;
    logic [4:0]  lu_issue_addr;
    logic        lu_valid;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        lu_ready;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        hazard_rs;
    logic        hazard_rt;
    logic        rf_we;
    logic [31:0] rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending;

    always #5 clk = ~clk;

    regfile_wport_arbiter #(.MAX_WAIT(MAX_WAIT), .ADDR_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_we         (wb_we),
        .wb_waddr      (wb_waddr),
        .wb_wdata      (wb_wdata),
        .wb_stall      (wb_stall),
        .lu_issue      (lu_issue),
        .lu_issue_addr (lu_issue_addr),
        .lu_valid      (lu_valid),
        .lu_waddr      (lu_waddr),
        .lu_wdata      (lu_wdata),
        .lu_ready      (lu_ready),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .hazard_rs     (hazard_rs),
        .hazard_rt     (hazard_rt),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .pending       (pending)
    );

    int total = 0;
    int bad   = 0;

    // Model: set of owed registers plus how long the current LU result has been refused.
    bit [31:0]   m_pend       = '0;
    int          m_denied     = 0;
    bit          m_last_stall = 1'b0;
    bit          m_last_ready = 1'b0;
    logic        e_we, e_rdy, e_stall, e_hrs, e_hrt, forced;
    logic [31:0] e_addr, e_data;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic lv, input logic [4:0] la, input logic [31:0] ld,
                                 input logic iss, input logic [4:0] ia,
                                 input logic [4:0] rs, input logic [4:0] rt);
        wb_we         = we;
        wb_waddr      = wa;
        wb_wdata      = wd;
        lu_valid      = lv;
        lu_waddr      = la;
        lu_wdata      = ld;
        lu_issue      = iss;
        lu_issue_addr = ia;
        rs_addr       = rs;
        rt_addr       = rt;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        e_we    = 1'b0;
        e_rdy   = 1'b0;
        e_stall = 1'b0;
        e_addr  = '0;
        e_data  = '0;
        if (rst) begin
            checkOutput("m_rst_rf_we", 32'(rf_we), 32'd0);
            checkOutput("m_rst_lu_ready", 32'(lu_ready), 32'd0);
            checkOutput("m_rst_wb_stall", 32'(wb_stall), 32'd0);
            checkOutput("m_rst_hazard_rs", 32'(hazard_rs), 32'd0);
            checkOutput("m_rst_hazard_rt", 32'(hazard_rt), 32'd0);
            m_pend       = '0;
            m_denied     = 0;
            m_last_stall = 1'b0;
            m_last_ready = 1'b0;
        end else begin
            forced = (m_denied == MAX_WAIT);
            if (forced) begin
                e_stall = 1'b1;
                e_rdy   = 1'b1;
                e_we    = lu_valid && (lu_waddr != 5'd0);
                e_addr  = 32'(lu_waddr);
                e_data  = lu_wdata;
            end else if (wb_we) begin
                e_we   = (wb_waddr != 5'd0);
                e_addr = 32'(wb_waddr);
                e_data = wb_wdata;
            end else if (lu_valid) begin
                e_rdy  = 1'b1;
                e_we   = (lu_waddr != 5'd0);
                e_addr = 32'(lu_waddr);
                e_data = lu_wdata;
            end
            e_hrs = (rs_addr != 5'd0) && m_pend[rs_addr];
            e_hrt = (rt_addr != 5'd0) && m_pend[rt_addr];
            checkOutput("m_rf_we", 32'(rf_we), 32'(e_we));
            checkOutput("m_lu_ready", 32'(lu_ready), 32'(e_rdy));
            checkOutput("m_wb_stall", 32'(wb_stall), 32'(e_stall));
            checkOutput("m_hazard_rs", 32'(hazard_rs), 32'(e_hrs));
            checkOutput("m_hazard_rt", 32'(hazard_rt), 32'(e_hrt));
            checkOutput("m_pending", pending, m_pend);
            if (e_we) begin
                checkOutput("m_rf_waddr", rf_waddr, e_addr);
                checkOutput("m_rf_wdata", rf_wdata, e_data);
            end
            if (forced || !(lu_valid && wb_we)) m_denied = 0;
            else m_denied++;
            if (lu_valid && e_rdy) m_pend[lu_waddr] = 1'b0;
            if (lu_issue && lu_issue_addr != 5'd0) m_pend[lu_issue_addr] = 1'b1;
            m_last_stall = e_stall;
            m_last_ready = e_rdy;
        end
    end

    initial begin
        rst = 1'b1;
        applyStimulus(0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("reset_rf_we", 32'(rf_we), 32'd0);
        checkOutput("reset_lu_ready", 32'(lu_ready), 32'd0);
        checkOutput("reset_wb_stall", 32'(wb_stall), 32'd0);
        cyc();
        rst = 1'b0;

        // WB pass-through
        applyStimulus(1, 5'd12, 32'hDEAD_BEEF, 0, 5'd0, 0, 0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("wb_rf_we", 32'(rf_we), 32'd1);
        checkOutput("wb_rf_waddr", rf_waddr, 32'd12);
        checkOutput("wb_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
        checkOutput("wb_lu_ready", 32'(lu_ready), 32'd0);
        checkOutput("wb_stall", 32'(wb_stall), 32'd0);
        checkOutput("reset_pending", pending, 32'd0);
        cyc();

        // Idle-gap grant
        applyStimulus(0, 5'd0, 0, 1, 5'd13, 32'd7, 0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("gap_lu_ready", 32'(lu_ready), 32'd1);
        checkOutput("gap_rf_we", 32'(rf_we), 32'd1);
        checkOutput("gap_rf_waddr", rf_waddr, 32'd13);
        checkOutput("gap_rf_wdata", rf_wdata, 32'd7);
        cyc();

        // Starvation: four denials, forced grant on the fifth cycle
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(1, 5'd3, 32'h33, (k <= 5), 5'd9, 32'd99, 0, 5'd0, 5'd0, 5'd0);
            @(negedge clk);
            if (k <= 4) begin
                checkOutput("starve_lu_ready", 32'(lu_ready), 32'd0);
                checkOutput("starve_wb_stall", 32'(wb_stall), 32'd0);
                checkOutput("starve_rf_waddr", rf_waddr, 32'd3);
            end else if (k == 5) begin
                checkOutput("force_wb_stall", 32'(wb_stall), 32'd1);
                checkOutput("force_lu_ready", 32'(lu_ready), 32'd1);
                checkOutput("force_rf_waddr", rf_waddr, 32'd9);
                checkOutput("force_rf_wdata", rf_wdata, 32'd99);
            end else begin
                checkOutput("resume_wb_stall", 32'(wb_stall), 32'd0);
                checkOutput("resume_rf_waddr", rf_waddr, 32'd3);
            end
            cyc();
        end

        // Scoreboard set, clear, and set-wins collision
        applyStimulus(0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd14, 5'd14, 5'd0);
        @(negedge clk);
        checkOutput("sb_pre_hazard", 32'(hazard_rs), 32'd0);
        cyc();
        applyStimulus(0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 5'd14, 5'd0);
        @(negedge clk);
        checkOutput("sb_set_pending", pending, 32'h0000_4000);
        checkOutput("sb_set_hazard", 32'(hazard_rs), 32'd1);
        cyc();
        applyStimulus(0, 5'd0, 0, 1, 5'd14, 32'd5, 0, 5'd0, 5'd14, 5'd0);
        @(negedge clk);
        checkOutput("sb_clr_ready", 32'(lu_ready), 32'd1);
        cyc();
        applyStimulus(0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 5'd14, 5'd0);
        @(negedge clk);
        checkOutput("sb_clr_pending", pending, 32'd0);
        checkOutput("sb_clr_hazard", 32'(hazard_rs), 32'd0);
        cyc();
        applyStimulus(0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd14, 5'd0, 5'd0);
        cyc();
        applyStimulus(0, 5'd0, 0, 1, 5'd14, 32'd6, 1, 5'd14, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("sb_both_ready", 32'(lu_ready), 32'd1);
        cyc();
        applyStimulus(0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 5'd14, 5'd14);
        @(negedge clk);
        checkOutput("sb_setwins_pending", pending, 32'h0000_4000);
        checkOutput("sb_setwins_hazard_rt", 32'(hazard_rt), 32'd1);
        cyc();

        // Register $0
        applyStimulus(0, 5'd0, 0, 0, 5'd0, 0, 1, 5'd0, 5'd0, 5'd0);
        cyc();
        applyStimulus(0, 5'd0, 0, 1, 5'd0, 32'd123, 0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("r0_pending", pending, 32'h0000_4000);
        checkOutput("r0_hazard", 32'(hazard_rs), 32'd0);
        checkOutput("r0_lu_ready", 32'(lu_ready), 32'd1);
        checkOutput("r0_rf_we", 32'(rf_we), 32'd0);
        cyc();

        // Sync reset landing on the forced cycle
        for (int k = 1; k <= 5; k++) begin
            rst = (k == 5);
            applyStimulus(1, 5'd5, 32'h55, 1, 5'd20, 32'd77, 0, 5'd0, 5'd14, 5'd0);
            @(negedge clk);
            if (k <= 4) begin
                checkOutput("rf_starve_ready", 32'(lu_ready), 32'd0);
            end else begin
                checkOutput("rf_rst_rf_we", 32'(rf_we), 32'd0);
                checkOutput("rf_rst_lu_ready", 32'(lu_ready), 32'd0);
                checkOutput("rf_rst_wb_stall", 32'(wb_stall), 32'd0);
                checkOutput("rf_rst_hazard", 32'(hazard_rs), 32'd0);
            end
            cyc();
        end
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_pending", pending, 32'd0);
        checkOutput("post_rst_wb_stall", 32'(wb_stall), 32'd0);
        checkOutput("post_rst_lu_ready", 32'(lu_ready), 32'd0);
        checkOutput("post_rst_rf_waddr", rf_waddr, 32'd5);
        cyc();
        wb_we = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_grant", 32'(lu_ready), 32'd1);
        checkOutput("post_rst_rf_waddr_lu", rf_waddr, 32'd20);
        checkOutput("post_rst_rf_wdata_lu", rf_wdata, 32'd77);
        cyc();

        // Randomized traffic honouring both handshake rules
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            if (!m_last_stall) begin
                wb_we    = ($urandom_range(0, 9) < 7);
                wb_waddr = 5'($urandom_range(0, 7));
                wb_wdata = $urandom;
            end
            if (!lu_valid || m_last_ready) begin
                lu_valid = ($urandom_range(0, 1) == 1);
                lu_waddr = 5'($urandom_range(0, 7));
                lu_wdata = $urandom;
            end
            lu_issue      = ($urandom_range(0, 3) == 0);
            lu_issue_addr = 5'($urandom_range(0, 7));
            rs_addr       = 5'($urandom_range(0, 7));
            rt_addr       = 5'($urandom_range(0, 7));
            cyc();
        end

        rst = 1'b0;
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
